// File: rtl/ifill_resp.sv
// rtl/ifill_resp.sv - L1 I-cache refill responder: fetches a line as sequential beats and returns it.
// Optional one-entry line buffer enabled by defining IFILL_LBUF_EN.
module ifill_resp #(
    parameter int BLK_LEN = 59,
    parameter int LINE    = 256,
    parameter int BEAT    = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BLK_LEN-1:0] b_addr_i,
    input  logic               b_rd_i,
    output logic [LINE-1:0]    b_data_i,
    output logic               b_dv_i,
    output logic [63:0]        m_addr,
    output logic               m_rd,
    input  logic [BEAT-1:0]    m_data,
    input  logic               m_dv
);

    localparam int N  = LINE / BEAT;
    localparam int CW = $clog2(N);
    localparam int OW = $clog2(BEAT / 8);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_BEAT = 3'd2;
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          hit;

    assign last   = (cnt == CW'(N - 1));
    assign m_rd   = (state == S_BEAT);
    assign b_dv_i = (state == S_RESP) && b_rd_i;

`ifdef IFILL_LBUF_EN
    logic [BLK_LEN-1:0] blk;
    logic [BLK_LEN-1:0] lb_tag;
    logic               lb_v;

    assign hit = lb_v && (b_addr_i == lb_tag);

    // The line data lives in b_data_i, so the entry is invalid while a miss overwrites it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk    <= '0;
            lb_tag <= '0;
            lb_v   <= 1'b0;
        end else begin
            if (state == S_ADDR) begin
                blk <= b_addr_i;
                if (!hit) begin
                    lb_v <= 1'b0;
                end
            end
            if (state == S_BEAT && m_dv && last) begin
                lb_tag <= blk;
                lb_v   <= 1'b1;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            m_addr   <= '0;
            b_data_i <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (b_rd_i) begin
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    cnt    <= '0;
                    m_addr <= 64'({b_addr_i, {CW{1'b0}}, {OW{1'b0}}});
                    state  <= hit ? S_RESP : S_BEAT;
                end
                S_BEAT: begin
                    if (m_dv) begin
                        b_data_i[BEAT*cnt +: BEAT] <= m_data;
                        cnt    <= cnt + 1'b1;
                        m_addr <= m_addr + 64'(BEAT / 8);
                        if (last) begin
                            state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Hold here until the L1 releases the request so it is served once.
                    if (!b_rd_i) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifill_resp.sv
// tb/tb_ifill_resp.sv - randomized scoreboard bench for ifill_resp with a behavioural memory and line model.
module tb_ifill_resp;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [58:0]   b_addr_i = '0;
    logic          b_rd_i = 1'b0;
    logic [255:0]  b_data_i;
    logic          b_dv_i;
    logic [63:0]   m_addr;
    logic          m_rd;
    logic [63:0]   m_data = '0;
    logic          m_dv = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ndv = 0;
    int lat = 1;
    int wt = 0;
    bit stray = 0;

    typedef struct {
        logic [255:0] line;
        int           cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] addr_q[$];

    logic [255:0] last_line = '0;
    bit           lb_ok = 0;
    logic [58:0]  lb_t = '0;

    ifill_resp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .b_addr_i (b_addr_i),
        .b_rd_i   (b_rd_i),
        .b_data_i (b_data_i),
        .b_dv_i   (b_dv_i),
        .m_addr   (m_addr),
        .m_rd     (m_rd),
        .m_data   (m_data),
        .m_dv     (m_dv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: the 0x800 line holds the 0x11..44 pattern, everything else a hash of the address.
    function automatic logic [63:0] mem(input logic [63:0] a);
        logic [7:0] b;
        if (a >= 64'h800 && a < 64'h820) begin
            b = 8'(8'h11 * (8'(a[4:3]) + 8'd1));
            return {8{b}};
        end
        return {a[31:0] ^ 32'hC3A5_5A3C, ~a[31:0] + 32'h1234_5678};
    endfunction

    function automatic logic [255:0] model_line(input logic [58:0] a);
        logic [255:0] l;
        logic [63:0]  base;
        base = {a, 5'b0};
        for (int i = 0; i < 4; i++) l[64*i +: 64] = mem(base + 64'(8 * i));
        return l;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Memory responder: completes the presented address lat cycles after it appears.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_dv = 1'b0;
                wt = 0;
            end else if (m_rd) begin
                if (wt >= lat - 1) begin
                    wt = 0;
                    m_dv = 1'b1;
                    m_data = mem(m_addr);
                    if (addr_q.size() == 0) begin
                        chk("unexpected_m_rd", 256'(m_addr), 256'(64'hFFFF_FFFF_FFFF_FFFF));
                    end else begin
                        chk("m_addr", 256'(m_addr), 256'(addr_q.pop_front()));
                    end
                end else begin
                    wt++;
                    m_dv = 1'b0;
                end
            end else begin
                wt = 0;
                m_dv = stray ? 1'($urandom_range(0, 1)) : 1'b0;
                m_data = {$urandom, $urandom};
            end
        end
    end

    // Response monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && b_dv_i) begin
                ndv++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_b_dv", 256'(cyc), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("b_data_i", b_data_i, e.line);
                    chk("b_dv_cycle", 256'(cyc), 256'(e.cyc));
                end
            end
        end
    end

    task automatic req(input logic [58:0] a, input int l, input int hold);
        int   t0;
        int   target;
        bit   hit;
        logic [255:0] line;
        hit = 0;
`ifdef IFILL_LBUF_EN
        hit = lb_ok && (lb_t == a);
`endif
        lat = l;
        line = model_line(a);
        if (!hit) for (int i = 0; i < 4; i++) addr_q.push_back({a, 5'b0} + 64'(8 * i));
        t0 = cyc;
        exp_q.push_back('{line, t0 + (hit ? 2 : 2 + 4 * l)});
        target = ndv + 1;
        b_addr_i = a;
        b_rd_i = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            if (ndv >= target) break;
        end
        if (ndv < target) begin
            chk("b_dv_timeout", 256'(ndv), 256'(target));
            exp_q.delete();
            addr_q.delete();
        end
        lb_ok = 1;
        lb_t = a;
        last_line = line;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk("hold_quiet", {b_data_i, m_rd, b_dv_i}, {last_line, 2'b00});
        end
        b_rd_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] k_line;
        logic [58:0]  ra;
        k_line = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("reset_idle", {b_data_i, m_addr, m_rd, b_dv_i}, '0);
        end

        req(59'h40, 1, 0);
        chk("line_0x40", b_data_i, k_line);

        req(59'h80, 3, 5);

        stray = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("stray_idle", {b_data_i, m_rd, b_dv_i}, {last_line, 2'b00});
        end
        req(59'h1234, 2, 4);
        stray = 0;

        // Reset during the third beat of a fill.
        lat = 1;
        for (int i = 0; i < 4; i++) addr_q.push_back(64'h800 + 64'(8 * i));
        b_addr_i = 59'h40;
        b_rd_i = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #1;
            if (addr_q.size() <= 1) break;
        end
        chk("reached_beat3", 256'(addr_q.size()), 256'(1));
        rst_n = 1'b0;
        b_rd_i = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_abort", {b_data_i, m_addr, m_rd, b_dv_i}, '0);
        addr_q.delete();
        exp_q.delete();
        lb_ok = 0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        req(59'h41, 1, 0);
        req(59'h40, 2, 0);

        // Repeat request: a line-buffer hit when enabled, otherwise a full fill.
        req(59'h40, 1, 0);
        req(59'h40, 3, 2);
        req(59'h41, 1, 0);

        for (int i = 0; i < 25; i++) begin
            stray = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 2) == 0) ? lb_t : 59'({$urandom, $urandom});
            req(ra, $urandom_range(1, 4), $urandom_range(0, 3));
        end
        stray = 0;

        repeat (5) @(negedge clk);
        chk("queues_drained", 256'(exp_q.size() + addr_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifill_resp.md
# ifill_resp

Responder end of the L1 instruction-cache refill interface. Accepts a line request (`b_rd_i`, `b_addr_i`) from the L1 I-cache, fetches the line from the backing memory port as sequential `BEAT`-bit reads, assembles it, and returns it with a single-cycle `b_dv_i` pulse. It sits between the L1 I-cache and the L2/memory bus.

## Interface
- `BLK_LEN`, 59: block address width, equal to the L1 `IMEM_BLK_LEN` (64 − log2(LINE/8)).
- `LINE`, 256: line width in bits, equal to the L1 `IMEM_LINE`.
- `BEAT`, 64: memory beat width in bits. `LINE/BEAT` is a power of two, ≥ 2.
- `clk  in  1  clock`
- `rst_n  in  1  reset, synchronous, active-low`
- `b_addr_i  in  BLK_LEN  requested block address from the L1`
- `b_rd_i  in  1  line request, held high by the L1 until it samples b_dv_i`
- `b_data_i  out  LINE  assembled line; registered`
- `b_dv_i  out  1  line valid, one-cycle pulse`
- `m_addr  out  64  byte address of the current beat; registered`
- `m_rd  out  1  beat read request`
- `m_data  in  BEAT  beat data`
- `m_dv  in  1  beat valid, one-cycle pulse per beat`

## Operation
- States: IDLE, ADDR, BEAT, RESP, WAIT.
- IDLE: if `b_rd_i`=1, go to ADDR. The L1 registers `b_addr_i` during its first fetch cycle, so the address is not sampled in IDLE.
- ADDR: latch `b_addr_i` into `blk`. Clear the beat counter `cnt` (log2(LINE/BEAT) bits). Set `m_addr` = {blk, cnt, log2(BEAT/8) zero bits}. Go to BEAT, or to RESP on a line-buffer hit (see Configuration).
- BEAT: `m_rd`=1. On `m_dv`=1:
  - Write `m_data` into `b_data_i[BEAT*cnt +: BEAT]`. Beat 0 is the lowest address and goes to the LSBs.
  - Increment `cnt` and advance `m_addr` by BEAT/8 on the same edge.
  - If the beat was the last one (`cnt`=LINE/BEAT−1), go to RESP and drop `m_rd`.
- `m_rd` stays high across consecutive beats. The memory treats each `m_dv` as completing the address presented in that cycle. One beat is outstanding at a time.
- RESP: `b_dv_i` = `b_rd_i`. Go to WAIT.
- WAIT: when `b_rd_i`=0, go to IDLE. This blocks a held request from being served twice.
- `m_dv` outside BEAT is ignored.
- If `b_rd_i` drops mid-fill, the fill still completes and updates `b_data_i`, but no `b_dv_i` pulse is issued.
- `b_data_i` holds its value between fills. It changes only on `m_dv` in BEAT.

## Timing
- Reset values: `b_dv_i`=0, `m_rd`=0, `m_addr`=0, `b_data_i`=0, state IDLE, line buffer invalid.
- Reset mid-fill aborts immediately: all outputs return to reset values on the next edge, and the partial line is discarded.
- Cycle 0: `b_rd_i` rises (IDLE).
- Cycle 1: ADDR.
- Cycle 2: first `m_rd`.
- With memory latency L (`m_dv` L cycles after the address is presented; L=1 means the same cycle), `b_dv_i` asserts at cycle 2 + N·L, where N = LINE/BEAT.
- `b_dv_i` is high for exactly one cycle. `b_data_i` is valid in that cycle and stays stable afterwards.
- Minimum back-to-back spacing: a new request is accepted no earlier than the cycle after `b_rd_i` is seen low in WAIT.

## Configuration
- `IFILL_LBUF_EN` defined:
  - Adds a one-entry line buffer: `lb_tag` (BLK_LEN bits) and `lb_v`. The data is the `b_data_i` register itself.
  - On completion of the last beat, set `lb_tag`=blk and `lb_v`=1.
  - In ADDR, if `lb_v` and `b_addr_i`==`lb_tag`, go straight to RESP with no memory access. `b_dv_i` then arrives at cycle 2.
  - Reset or an aborted fill clears `lb_v`.
- `IFILL_LBUF_EN` undefined: every request performs a full memory fill, and no tag/valid state exists.

## Test plan
- Reset, then idle 10 cycles:
  - Required: `b_dv_i`=0, `m_rd`=0, `m_addr`=0, `b_data_i`=0 throughout.
- Fill with `b_addr_i`=0x40, L=1, memory returning beats 0x11..11, 0x22..22, 0x33..33, 0x44..44:
  - `m_addr` sequence: 0x800, 0x808, 0x810, 0x818.
  - `b_dv_i` pulses once at cycle 6.
  - `b_data_i`={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- L=3 fill:
  - `b_dv_i` at cycle 14.
  - `b_rd_i` held high for 5 cycles after the pulse: no second `m_rd` and no second `b_dv_i`.
- Stray `m_dv` pulses in IDLE and in WAIT:
  - `b_data_i` unchanged, no state change.
- Reset asserted on the 3rd beat, then a new request for 0x41:
  - All outputs at reset values the cycle after reset.
  - The new fill fetches from 0x820.
  - With `IFILL_LBUF_EN`, a following request for 0x40 is a miss.
- With `IFILL_LBUF_EN`: fill 0x40, release `b_rd_i`, then request 0x40 again:
  - `b_dv_i` at cycle 2 with no `m_rd`, same data.
  - A request for 0x41 then performs a full fill.
